// File: rtl/midi_msg_parser.sv
`default_nettype none
// ============================================================================
// midi_msg_parser : assembles received MIDI bytes into complete messages
// (running status, SysEx skip, real-time passthrough, valid/ready output).
// Revision: 1.0
// ============================================================================
module midi_msg_parser #(
  parameter bit NORM_NOTEOFF = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_res,
  input  logic       i_rx_flg,
  input  logic [7:0] i_rx_data,
  output logic       o_msg_vld,
  input  logic       i_msg_rdy,
  output logic [7:0] o_status,
  output logic [6:0] o_data1,
  output logic [6:0] o_data2,
  output logic       o_rt_vld,
  output logic [7:0] o_rt_byte,
  output logic       o_err,
  output logic       o_ovf
);

  typedef enum logic [1:0] {
    NO_RS   = 2'd0,
    WAIT_D1 = 2'd1,
    WAIT_D2 = 2'd2,
    SYSEX   = 2'd3
  } state_t;

  state_t     state;
  logic [7:0] cur_status;  // doubles as the running status while rs_valid is set
  logic       rs_valid;
  logic [6:0] data1_q;

  logic       is_rt;
  logic       is_data;
  logic       accept;
  logic       done;
  logic [7:0] new_status;
  logic [6:0] new_d1;
  logic [6:0] new_d2;

  function automatic logic one_data_byte(input logic [7:0] s);
    return (s[7:4] == 4'hC) || (s[7:4] == 4'hD) || (s == 8'hF1) || (s == 8'hF3);
  endfunction

  always_comb begin
    is_rt      = (i_rx_data[7:3] == 5'b11111);
    is_data    = ~i_rx_data[7];
    accept     = o_msg_vld & i_msg_rdy;
    done       = 1'b0;
    new_status = cur_status;
    new_d1     = 7'd0;
    new_d2     = 7'd0;
    if (i_rx_flg && !is_rt) begin
      if (i_rx_data == 8'hF6) begin
        done       = 1'b1;
        new_status = 8'hF6;
      end else if (is_data && (state == WAIT_D1) && one_data_byte(cur_status)) begin
        done   = 1'b1;
        new_d1 = i_rx_data[6:0];
      end else if (is_data && (state == WAIT_D2)) begin
        done   = 1'b1;
        new_d1 = data1_q;
        new_d2 = i_rx_data[6:0];
      end
    end
    // Note On with zero velocity is reported as Note Off on the same channel
    if (NORM_NOTEOFF && (new_status[7:4] == 4'h9) && (new_d2 == 7'd0)) begin
      new_status[7:4] = 4'h8;
    end
  end

  always_ff @(posedge i_clk or posedge i_res) begin
    if (i_res) begin
      state      <= NO_RS;
      cur_status <= 8'd0;
      rs_valid   <= 1'b0;
      data1_q    <= 7'd0;
      o_msg_vld  <= 1'b0;
      o_status   <= 8'd0;
      o_data1    <= 7'd0;
      o_data2    <= 7'd0;
      o_rt_vld   <= 1'b0;
      o_rt_byte  <= 8'd0;
      o_err      <= 1'b0;
      o_ovf      <= 1'b0;
    end else begin
      o_rt_vld <= 1'b0;
      o_err    <= 1'b0;
      o_ovf    <= 1'b0;

      if (done) begin
        if (!o_msg_vld || accept) begin
          o_msg_vld <= 1'b1;
          o_status  <= new_status;
          o_data1   <= new_d1;
          o_data2   <= new_d2;
        end else begin
          o_ovf <= 1'b1;
        end
      end else if (accept) begin
        o_msg_vld <= 1'b0;
      end

      if (i_rx_flg) begin
        if (is_rt) begin
          o_rt_vld  <= 1'b1;
          o_rt_byte <= i_rx_data;
        end else if (is_data) begin
          case (state)
            NO_RS: o_err <= 1'b1;
            WAIT_D1: begin
              data1_q <= i_rx_data[6:0];
              if (!one_data_byte(cur_status)) begin
                state <= WAIT_D2;
              end else if (!rs_valid) begin
                state <= NO_RS;
              end
            end
            WAIT_D2: begin
              data1_q <= 7'd0;
              state   <= rs_valid ? WAIT_D1 : NO_RS;
            end
            default: state <= state;
          endcase
        end else begin
          data1_q <= 7'd0;
          if (i_rx_data < 8'hF0) begin
            cur_status <= i_rx_data;
            rs_valid   <= 1'b1;
            state      <= WAIT_D1;
          end else begin
            rs_valid <= 1'b0;
            case (i_rx_data)
              8'hF0: state <= SYSEX;
              8'hF1, 8'hF2, 8'hF3: begin
                cur_status <= i_rx_data;
                state      <= WAIT_D1;
              end
              default: state <= NO_RS;
            endcase
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_midi_msg_parser.sv
`default_nettype none
// Testbench for midi_msg_parser: directed scenarios plus randomized bytes
// checked against a message-level reference model.
module tb_midi_msg_parser;

  logic       clk = 1'b0;
  logic       res;
  logic       rx_flg;
  logic [7:0] rx_data;
  logic       msg_rdy;
  logic       msg_vld;
  logic [7:0] status;
  logic [6:0] data1;
  logic [6:0] data2;
  logic       rt_vld;
  logic [7:0] rt_byte;
  logic       err;
  logic       ovf;

  int checks   = 0;
  int failures = 0;

  // reference model state
  bit         m_vld, m_rt, m_err, m_ovf;
  logic [7:0] m_status, m_rt_byte;
  logic [6:0] m_d1, m_d2;
  int         m_rs, m_cur;
  bit         m_sysex;
  logic [6:0] m_part[$];

  midi_msg_parser #(.NORM_NOTEOFF(1'b1)) dut (
    .i_clk    (clk),
    .i_res    (res),
    .i_rx_flg (rx_flg),
    .i_rx_data(rx_data),
    .o_msg_vld(msg_vld),
    .i_msg_rdy(msg_rdy),
    .o_status (status),
    .o_data1  (data1),
    .o_data2  (data2),
    .o_rt_vld (rt_vld),
    .o_rt_byte(rt_byte),
    .o_err    (err),
    .o_ovf    (ovf)
  );

  always #10 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic int msg_len(input int s);
    if (s == 8'hF2) return 2;
    if (s >= 8'hF0) return 1;
    if ((s / 16) == 12 || (s / 16) == 13) return 1;
    return 2;
  endfunction

  task automatic model_reset();
    m_vld = 0; m_rt = 0; m_err = 0; m_ovf = 0;
    m_status = 0; m_rt_byte = 0; m_d1 = 0; m_d2 = 0;
    m_rs = -1; m_cur = -1; m_sysex = 0;
    m_part.delete();
  endtask

  task automatic model_edge(input bit flg, input logic [7:0] d, input bit rdy);
    bit done;
    bit acc;
    logic [7:0] s;
    logic [6:0] a, b;
    done = 0; s = 0; a = 0; b = 0;
    m_rt = 0; m_err = 0; m_ovf = 0;
    if (flg) begin
      if (d >= 8'hF8) begin
        m_rt = 1; m_rt_byte = d;
      end else if (d < 8'h80) begin
        if (!m_sysex) begin
          if (m_cur < 0) m_err = 1;
          else begin
            m_part.push_back(d[6:0]);
            if (m_part.size() == msg_len(m_cur)) begin
              done = 1;
              s = 8'(m_cur);
              a = m_part[0];
              b = (m_part.size() > 1) ? m_part[1] : 7'h0;
              m_part.delete();
              if (m_rs < 0) m_cur = -1;
            end
          end
        end
      end else begin
        m_part.delete();
        m_sysex = (d == 8'hF0);
        if (d < 8'hF0) begin
          m_rs = int'(d); m_cur = int'(d);
        end else begin
          m_rs = -1;
          m_cur = (d == 8'hF1 || d == 8'hF2 || d == 8'hF3) ? int'(d) : -1;
          if (d == 8'hF6) begin done = 1; s = 8'hF6; end
        end
      end
    end
    if (done && s >= 8'h90 && s <= 8'h9F && b == 0) s = s - 8'h10;
    acc = m_vld && rdy;
    if (done) begin
      if (!m_vld || acc) begin
        m_vld = 1; m_status = s; m_d1 = a; m_d2 = b;
      end else m_ovf = 1;
    end else if (acc) m_vld = 0;
  endtask

  task automatic step(input bit flg, input logic [7:0] d, input bit rdy);
    rx_flg = flg; rx_data = d; msg_rdy = rdy;
    @(posedge clk);
    model_edge(flg, d, rdy);
    #1;
  endtask

  function automatic logic [33:0] obs_vec();
    return {msg_vld, msg_vld ? status : 8'h0, msg_vld ? data1 : 7'h0, msg_vld ? data2 : 7'h0,
            rt_vld, rt_vld ? rt_byte : 8'h0, err, ovf};
  endfunction

  function automatic logic [33:0] exp_vec();
    return {m_vld, m_vld ? m_status : 8'h0, m_vld ? m_d1 : 7'h0, m_vld ? m_d2 : 7'h0,
            m_rt, m_rt ? m_rt_byte : 8'h0, m_err, m_ovf};
  endfunction

  task automatic test_reset();
    rx_flg = 0; rx_data = 0; msg_rdy = 0; res = 1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({msg_vld, status, data1, data2, rt_vld, rt_byte, err, ovf} !== 34'h0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0", {msg_vld, status, data1, data2, rt_vld, rt_byte, err, ovf});
    end
    @(negedge clk);
    res = 0;
    step(1, 8'h3C, 1);
    checks++;
    if ({err, msg_vld} !== 2'b10) begin
      failures++; $display("FAIL data_in_no_rs got=%b exp=10", {err, msg_vld});
    end
    step(0, 8'h00, 1);
    checks++;
    if (err !== 1'b0) begin
      failures++; $display("FAIL err_pulse_width got=%b exp=0", err);
    end
  endtask

  task automatic test_note_on();
    step(1, 8'h90, 1);
    step(1, 8'h3C, 1);
    checks++;
    if (msg_vld !== 1'b0) begin
      failures++; $display("FAIL note_on_early got=%b exp=0", msg_vld);
    end
    step(1, 8'h64, 1);
    checks++;
    if ({msg_vld, status, data1, data2} !== {1'b1, 8'h90, 7'h3C, 7'h64}) begin
      failures++; $display("FAIL note_on_msg got=%h exp=%h", {msg_vld, status, data1, data2}, {1'b1, 8'h90, 7'h3C, 7'h64});
    end
    step(0, 8'h55, 1);
    checks++;
    if (msg_vld !== 1'b0) begin
      failures++; $display("FAIL note_on_accept got=%b exp=0", msg_vld);
    end
  endtask

  task automatic test_back_to_back();
    step(1, 8'h93, 1);
    step(1, 8'h3C, 1);
    step(1, 8'h64, 1);
    checks++;
    if ({msg_vld, status, data1, data2} !== {1'b1, 8'h93, 7'h3C, 7'h64}) begin
      failures++; $display("FAIL b2b_msg1 got=%h exp=%h", {msg_vld, status, data1, data2}, {1'b1, 8'h93, 7'h3C, 7'h64});
    end
    step(1, 8'h40, 1);
    checks++;
    if (msg_vld !== 1'b0) begin
      failures++; $display("FAIL b2b_gap got=%b exp=0", msg_vld);
    end
    step(1, 8'h00, 1);
    checks++;
    if ({msg_vld, status, data1, data2} !== {1'b1, 8'h83, 7'h40, 7'h00}) begin
      failures++; $display("FAIL b2b_noteoff got=%h exp=%h", {msg_vld, status, data1, data2}, {1'b1, 8'h83, 7'h40, 7'h00});
    end
    step(1, 8'hC5, 1);
    step(1, 8'h10, 1);
    checks++;
    if ({msg_vld, status, data1, data2} !== {1'b1, 8'hC5, 7'h10, 7'h00}) begin
      failures++; $display("FAIL b2b_progchg got=%h exp=%h", {msg_vld, status, data1, data2}, {1'b1, 8'hC5, 7'h10, 7'h00});
    end
    step(0, 8'h00, 1);
  endtask

  task automatic test_realtime();
    step(1, 8'h90, 1);
    step(1, 8'hF8, 1);
    checks++;
    if ({rt_vld, rt_byte, msg_vld} !== {1'b1, 8'hF8, 1'b0}) begin
      failures++; $display("FAIL rt_pulse got=%h exp=%h", {rt_vld, rt_byte, msg_vld}, {1'b1, 8'hF8, 1'b0});
    end
    step(1, 8'h3C, 1);
    checks++;
    if (rt_vld !== 1'b0) begin
      failures++; $display("FAIL rt_pulse_width got=%b exp=0", rt_vld);
    end
    step(1, 8'h64, 1);
    checks++;
    if ({msg_vld, status, data1, data2} !== {1'b1, 8'h90, 7'h3C, 7'h64}) begin
      failures++; $display("FAIL rt_msg got=%h exp=%h", {msg_vld, status, data1, data2}, {1'b1, 8'h90, 7'h3C, 7'h64});
    end
    step(0, 8'h00, 1);
  endtask

  task automatic test_sysex();
    logic [7:0] seq [4];
    seq[0] = 8'hF0; seq[1] = 8'h7E; seq[2] = 8'h01; seq[3] = 8'hF7;
    for (int i = 0; i < 4; i++) begin
      step(1, seq[i], 1);
      checks++;
      if ({msg_vld, err} !== 2'b00) begin
        failures++; $display("FAIL sysex_quiet[%0d] got=%b exp=00", i, {msg_vld, err});
      end
    end
    step(1, 8'h3C, 1);
    checks++;
    if ({msg_vld, err} !== 2'b01) begin
      failures++; $display("FAIL sysex_after_err got=%b exp=01", {msg_vld, err});
    end
    step(0, 8'h00, 1);
  endtask

  task automatic test_system_common();
    step(1, 8'hF2, 1); step(1, 8'h11, 1); step(1, 8'h22, 1);
    checks++;
    if ({msg_vld, status, data1, data2} !== {1'b1, 8'hF2, 7'h11, 7'h22}) begin
      failures++; $display("FAIL songpos got=%h exp=%h", {msg_vld, status, data1, data2}, {1'b1, 8'hF2, 7'h11, 7'h22});
    end
    step(1, 8'hF1, 1); step(1, 8'h05, 1);
    checks++;
    if ({msg_vld, status, data1, data2} !== {1'b1, 8'hF1, 7'h05, 7'h00}) begin
      failures++; $display("FAIL mtc got=%h exp=%h", {msg_vld, status, data1, data2}, {1'b1, 8'hF1, 7'h05, 7'h00});
    end
    // completion coincides with acceptance of the held F1 message
    step(1, 8'hF6, 1);
    checks++;
    if ({msg_vld, status, data1, data2, ovf} !== {1'b1, 8'hF6, 7'h00, 7'h00, 1'b0}) begin
      failures++; $display("FAIL tune_req got=%h exp=%h", {msg_vld, status, data1, data2, ovf}, {1'b1, 8'hF6, 7'h00, 7'h00, 1'b0});
    end
    step(1, 8'h7F, 1);
    checks++;
    if ({msg_vld, err} !== 2'b01) begin
      failures++; $display("FAIL after_f6_err got=%b exp=01", {msg_vld, err});
    end
    step(1, 8'hF3, 1); step(1, 8'h01, 1);
    step(1, 8'h02, 1);
    checks++;
    if ({msg_vld, err} !== 2'b01) begin
      failures++; $display("FAIL after_f3_err got=%b exp=01", {msg_vld, err});
    end
    step(1, 8'h90, 1); step(1, 8'hF4, 1); step(1, 8'h3C, 1);
    checks++;
    if ({msg_vld, err} !== 2'b01) begin
      failures++; $display("FAIL f4_clears_rs got=%b exp=01", {msg_vld, err});
    end
  endtask

  task automatic test_backpressure();
    step(1, 8'h90, 0); step(1, 8'h3C, 0); step(1, 8'h64, 0);
    step(1, 8'h90, 0); step(1, 8'h40, 0); step(1, 8'h50, 0);
    checks++;
    if ({msg_vld, status, data1, data2, ovf} !== {1'b1, 8'h90, 7'h3C, 7'h64, 1'b1}) begin
      failures++; $display("FAIL bp_ovf got=%h exp=%h", {msg_vld, status, data1, data2, ovf}, {1'b1, 8'h90, 7'h3C, 7'h64, 1'b1});
    end
    step(0, 8'h00, 0);
    checks++;
    if ({msg_vld, status, data1, data2, ovf} !== {1'b1, 8'h90, 7'h3C, 7'h64, 1'b0}) begin
      failures++; $display("FAIL bp_hold got=%h exp=%h", {msg_vld, status, data1, data2, ovf}, {1'b1, 8'h90, 7'h3C, 7'h64, 1'b0});
    end
    step(0, 8'h00, 1);
    checks++;
    if ({msg_vld, ovf} !== 2'b00) begin
      failures++; $display("FAIL bp_accept got=%b exp=00", {msg_vld, ovf});
    end
    step(1, 8'h3C, 0); step(1, 8'h11, 0);
    step(1, 8'h22, 0);
    step(1, 8'h33, 1);
    checks++;
    if ({msg_vld, status, data1, data2, ovf} !== {1'b1, 8'h90, 7'h22, 7'h33, 1'b0}) begin
      failures++; $display("FAIL bp_same_cycle got=%h exp=%h", {msg_vld, status, data1, data2, ovf}, {1'b1, 8'h90, 7'h22, 7'h33, 1'b0});
    end
    step(0, 8'h00, 1);
  endtask

  task automatic test_reset_mid_msg();
    step(1, 8'h90, 0); step(1, 8'h3C, 0); step(1, 8'h64, 0);
    step(1, 8'h90, 0); step(1, 8'h3C, 0);
    #5;
    res = 1;
    model_reset();
    #1;
    checks++;
    if ({msg_vld, status, data1, data2, rt_vld, rt_byte, err, ovf} !== 34'h0) begin
      failures++;
      $display("FAIL async_reset got=%h exp=0", {msg_vld, status, data1, data2, rt_vld, rt_byte, err, ovf});
    end
    @(posedge clk);
    @(negedge clk);
    res = 0;
    step(1, 8'h64, 1);
    checks++;
    if ({msg_vld, err} !== 2'b01) begin
      failures++; $display("FAIL reset_mid_err got=%b exp=01", {msg_vld, err});
    end
    step(0, 8'h00, 1);
    checks++;
    if ({msg_vld, err} !== 2'b00) begin
      failures++; $display("FAIL reset_mid_quiet got=%b exp=00", {msg_vld, err});
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      int r;
      logic [7:0] d;
      bit f, y;
      r = $urandom_range(0, 99);
      if (r < 8) d = 8'h00;
      else if (r < 50) d = 8'($urandom_range(0, 127));
      else if (r < 75) d = 8'($urandom_range(128, 239));
      else if (r < 87) d = 8'($urandom_range(240, 247));
      else d = 8'($urandom_range(248, 255));
      f = ($urandom_range(0, 9) < 7);
      y = ($urandom_range(0, 9) < 6);
      step(f, d, y);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL random[%0d] byte=%h flg=%b rdy=%b got=%h exp=%h", i, d, f, y, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_note_on();
    test_back_to_back();
    test_realtime();
    test_sysex();
    test_system_common();
    test_backpressure();
    test_reset_mid_msg();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
